// File: rtl/shift_result_sequencer.sv
// shift_result_sequencer
// Captures the four results of a shifter stage (plus the shift amount) on a
// start request and streams them out as a five-word burst: sl_a, sr_a, sl_b,
// sr_b, then their XOR checksum. Each word carries its index on out_tag.
//
// Output handshake (valid/ready):
//   - out_valid is high for every cycle the FSM is in SEND.
//   - A word transfers on a rising clk edge where out_valid && out_ready.
//   - While out_valid is high and out_ready is low, data_out and out_tag
//     hold steady; no word is dropped or repeated.
//   - out_valid never depends combinationally on out_ready.
//
// The FSM state is exposed on fsm_state so that checkers can bind to it.
module shift_result_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sl_a,
  input  logic [WIDTH-1:0] sr_a,
  input  logic [WIDTH-1:0] sl_b,
  input  logic [WIDTH-1:0] sr_b,
  input  logic [1:0]       cantidad,
  input  logic             start,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  output logic [2:0]       out_tag,
  output logic [1:0]       out_amt,
  output logic             busy,
  output logic             done,
  output logic [1:0]       fsm_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] LAST_IDX = 3'd4;

  state_t           state;
  state_t           state_next;
  logic [2:0]       idx;
  logic [2:0]       idx_next;
  logic             capture;
  logic             transfer;

  logic [WIDTH-1:0] cap_sl_a;
  logic [WIDTH-1:0] cap_sr_a;
  logic [WIDTH-1:0] cap_sl_b;
  logic [WIDTH-1:0] cap_sr_b;
  logic [1:0]       cap_amt;

  logic [WIDTH-1:0] checksum;
  logic [WIDTH-1:0] word_sel;

  // Capture is only honoured in IDLE; a transfer is only possible in SEND.
  assign capture  = (state == IDLE) && start;
  assign transfer = (state == SEND) && out_ready;

  // Checksum is formed from the held copies, so input activity after capture
  // cannot disturb word 4.
  assign checksum = cap_sl_a ^ cap_sr_a ^ cap_sl_b ^ cap_sr_b;

  // State and word-index register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= 3'd0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  // Operand capture registers; loaded only on an accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_sl_a <= '0;
      cap_sr_a <= '0;
      cap_sl_b <= '0;
      cap_sr_b <= '0;
      cap_amt  <= 2'd0;
    end else if (capture) begin
      cap_sl_a <= sl_a;
      cap_sr_a <= sr_a;
      cap_sl_b <= sl_b;
      cap_sr_b <= sr_b;
      cap_amt  <= cantidad;
    end
  end

  // Next-state and next-index logic.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    case (state)
      IDLE: begin
        if (capture) begin
          state_next = SEND;
          idx_next   = 3'd0;
        end
      end
      SEND: begin
        if (transfer) begin
          if (idx == LAST_IDX) begin
            // Index parks at zero rather than running past the last word.
            state_next = DONE;
            idx_next   = 3'd0;
          end else begin
            idx_next = idx + 3'd1;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        idx_next   = 3'd0;
      end
    endcase
  end

  // Select the captured word for the current index.
  always_comb begin
    word_sel = checksum;
    case (idx)
      3'd0:    word_sel = cap_sl_a;
      3'd1:    word_sel = cap_sr_a;
      3'd2:    word_sel = cap_sl_b;
      3'd3:    word_sel = cap_sr_b;
      default: word_sel = checksum;
    endcase
  end

  // Outputs decoded from registered state; zero outside SEND, so a reset
  // clears them immediately without waiting for a clock.
  always_comb begin
    data_out  = '0;
    out_tag   = 3'd0;
    out_valid = 1'b0;
    done      = 1'b0;
    busy      = 1'b0;
    case (state)
      SEND: begin
        data_out  = word_sel;
        out_tag   = idx;
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      DONE: begin
        done = 1'b1;
        busy = 1'b1;
      end
      default: begin
        data_out  = '0;
        out_tag   = 3'd0;
      end
    endcase
  end

  assign out_amt   = cap_amt;
  assign fsm_state = state;

endmodule
